fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_queue_mem.sv | 34 +++
 rtl/fetch_queue.sv | 89 ++++++++
 tb/tb_fetch_queue.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, opcode field width and default queue depth.
// Imported by the fetch queue and its storage sub-module.
package cpu_pkg;

  localparam int DEFAULT_BUS_WIDTH = 32;
  localparam int OPCODE_WIDTH      = 7;
  localparam int DEFAULT_DEPTH     = 4;

  // Returns 1 when depth is a usable queue size: a power of two, at least 2.
  function automatic bit isValidDepth(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: {instruction, pc} array, one write port,
// and a combinational read mux.
module fetch_queue_mem
  import cpu_pkg::*;
#(
  parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH
) (
  input  logic                     CLK,
  input  logic                     writeEn,
  input  logic [$clog2(DEPTH)-1:0] writeAddr,
  input  logic [BUS_WIDTH-1:0]     writeData,
  input  logic [BUS_WIDTH-1:0]     writePc,
  input  logic [$clog2(DEPTH)-1:0] readAddr,
  output logic [BUS_WIDTH-1:0]     readData,
  output logic [BUS_WIDTH-1:0]     readPc
);

  logic [BUS_WIDTH-1:0] dataArr [DEPTH];
  logic [BUS_WIDTH-1:0] pcArr   [DEPTH];

  // NOTE: storage has no reset; stale entries are never visible because the
  // queue count, not the array contents, decides what is valid.
  always_ff @(posedge CLK) begin
    if (writeEn) begin
      dataArr[writeAddr] <= writeData;
      pcArr[writeAddr]   <= writePc;
    end
  end

  assign readData = dataArr[readAddr];
  assign readPc   = pcArr[readAddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, pointers and count, pushes one word
// per cycle from a combinational instruction memory and presents the head to decode.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int IMEM_WORDS = 256
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic [BUS_WIDTH-1:0]   imem_addr,
  input  logic [BUS_WIDTH-1:0]   imem_data,
  output logic [BUS_WIDTH-1:0]   instr_out,
  output logic [BUS_WIDTH-1:0]   instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect,
  input  logic [BUS_WIDTH-1:0]   redirect_pc,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   fetch_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [BUS_WIDTH-1:0] PC_END   = BUS_WIDTH'(IMEM_WORDS);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DEPTH);

  logic [BUS_WIDTH-1:0] pc;
  logic [PTR_W-1:0]     rdPtr;
  logic [PTR_W-1:0]     wrPtr;
  logic [CNT_W-1:0]     count;
  logic                 pcInRange;
  logic                 pushEn;
  logic                 popEn;

  // NOTE: every signal written here gets a value on every path, so no latch forms.
  always_comb begin
    pcInRange = (pc < PC_END);
    popEn     = (count != '0) && instr_ready && !redirect;
    // A full queue may still accept a word when the head leaves in the same cycle.
    pushEn    = !redirect && pcInRange && ((count < CNT_FULL) || popEn);
  end

  // NOTE: state registers use non-blocking assignments so every update sees
  // the pre-edge values of the others.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc    <= '0;
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else if (redirect) begin
      pc    <= redirect_pc;
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else begin
      if (pushEn) begin
        pc    <= pc + BUS_WIDTH'(1);
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (popEn) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      count <= count + CNT_W'(pushEn) - CNT_W'(popEn);
    end
  end

  fetch_queue_mem #(
    .BUS_WIDTH (BUS_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .CLK       (CLK),
    .writeEn   (pushEn),
    .writeAddr (wrPtr),
    .writeData (imem_data),
    .writePc   (pc),
    .readAddr  (rdPtr),
    .readData  (instr_out),
    .readPc    (instr_pc)
  );

  assign imem_addr   = pc;
  assign instr_valid = (count != '0);
  assign occupancy   = count;
  assign fetch_done  = !pcInRange && (count == '0);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a 256-word instance for fetch, stall, redirect
// and reset, and an 8-word instance for end-of-program behaviour.
module tb_fetch_queue;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic [31:0] imemAddr, imemData, instrOut, instrPc, redirectPc;
  logic        instrValid, instrReady, redirect, fetchDone;
  logic [2:0]  occupancy;

  logic [31:0] eImemAddr, eImemData, eInstrOut, eInstrPc, eRedirectPc;
  logic        eInstrValid, eInstrReady, eRedirect, eFetchDone;
  logic [2:0]  eOccupancy;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  always #5 CLK = ~CLK;

  assign imemData  = BASE + imemAddr;
  assign eImemData = BASE + eImemAddr;

  fetch_queue #(.BUS_WIDTH(32), .DEPTH(4), .IMEM_WORDS(256)) dut (
    .CLK (CLK), .RST (RST),
    .imem_addr (imemAddr), .imem_data (imemData),
    .instr_out (instrOut), .instr_pc (instrPc), .instr_valid (instrValid),
    .instr_ready (instrReady), .redirect (redirect), .redirect_pc (redirectPc),
    .occupancy (occupancy), .fetch_done (fetchDone)
  );

  fetch_queue #(.BUS_WIDTH(32), .DEPTH(4), .IMEM_WORDS(8)) dutEnd (
    .CLK (CLK), .RST (RST),
    .imem_addr (eImemAddr), .imem_data (eImemData),
    .instr_out (eInstrOut), .instr_pc (eInstrPc), .instr_valid (eInstrValid),
    .instr_ready (eInstrReady), .redirect (eRedirect), .redirect_pc (eRedirectPc),
    .occupancy (eOccupancy), .fetch_done (eFetchDone)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    instrReady = 1'b0; redirect = 1'b0; redirectPc = '0;
    eInstrReady = 1'b0; eRedirect = 1'b0; eRedirectPc = '0;

    // Reset state
    repeat (2) step();
    check("rst_valid", instrValid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_addr", imemAddr, 0);
    check("rst_done", fetchDone, 0);
    check("rst_done_end", eFetchDone, 0);

    // Free-running fetch
    RST = 1'b0;
    instrReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("run_out", instrOut, BASE + 32'(i));
      check("run_pc", instrPc, 32'(i));
      check("run_occ", occupancy, 1);
    end

    // Restart from 0, then stall until full
    redirect = 1'b1; redirectPc = 32'h0;
    step();
    check("rd0_occ", occupancy, 0);
    check("rd0_addr", imemAddr, 0);
    redirect = 1'b0; instrReady = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("stall_occ", occupancy, (i < 4) ? 32'(i) : 32'd4);
      check("stall_out", instrOut, BASE);
    end
    check("stall_pc_hold", imemAddr, 4);

    // Full with simultaneous pop
    instrReady = 1'b1;
    step();
    check("fullpop_occ", occupancy, 4);
    check("fullpop_addr", imemAddr, 5);
    check("fullpop_out", instrOut, BASE + 32'd1);
    check("fullpop_pc", instrPc, 1);
    for (int i = 2; i <= 7; i++) begin
      step();
      check("drain_pc", instrPc, 32'(i));
      check("drain_out", instrOut, BASE + 32'(i));
    end

    // Redirect with three entries queued
    redirect = 1'b1; redirectPc = 32'h40; instrReady = 1'b0;
    step();
    redirect = 1'b0;
    repeat (3) step();
    check("pre_rd_occ", occupancy, 3);
    redirect = 1'b1; redirectPc = 32'h20;
    step();
    check("rd_occ", occupancy, 0);
    check("rd_addr", imemAddr, 32'h20);
    check("rd_valid", instrValid, 0);
    redirect = 1'b0;
    step();
    check("rd_pc", instrPc, 32'h20);
    check("rd_out", instrOut, BASE + 32'h20);
    check("rd_occ1", occupancy, 1);

    // Asynchronous reset mid-cycle with two entries
    step();
    check("prerst_occ", occupancy, 2);
    #3;
    RST = 1'b1;
    #1;
    check("arst_valid", instrValid, 0);
    check("arst_occ", occupancy, 0);
    check("arst_addr", imemAddr, 0);
    step();
    RST = 1'b0;
    instrReady = 1'b1;
    eInstrReady = 1'b1;
    step();
    check("post_rst_pc", instrPc, 0);
    check("post_rst_valid", instrValid, 1);
    check("post_rst_out", instrOut, BASE);
    check("end_pc0", eInstrPc, 0);

    // End of program on the 8-word instance (step 1 already taken)
    for (int i = 2; i <= 8; i++) begin
      step();
      check("end_pc", eInstrPc, 32'(i - 1));
      check("end_done_low", eFetchDone, 0);
    end
    check("end_addr8", eImemAddr, 8);
    step();
    check("end_done", eFetchDone, 1);
    check("end_valid", eInstrValid, 0);
    check("end_addr_hold", eImemAddr, 8);
    step();
    check("end_addr_hold2", eImemAddr, 8);
    check("end_done_hold", eFetchDone, 1);
    eRedirect = 1'b1; eRedirectPc = 32'h2;
    step();
    eRedirect = 1'b0;
    check("end_rd_done", eFetchDone, 0);
    check("end_rd_addr", eImemAddr, 2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
